data_mem_responder: RTL and testbench

Memory-side responder for the data port driven by the pipeline memory stage. It services one read or one write at a time from an internal word-addressed array and returns read data or a write-complete pulse after a fixed, parameterized latency. It sits between the memory stage's S_R_*/S_W_* request signals and on-chip storage. It replaces an ideal testbench memory with a cycle-accurate model that the team can synthesize.

---
 rtl/data_mem_responder_if.sv | 34 +++
 rtl/data_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bundle between the pipeline memory stage (master) and
//   the data memory responder (slave).
//   Read channel : S_R_ADDR, S_R_ADDR_VALID (master -> slave)
//                  S_R_DATA, S_R_DATA_VALID (slave -> master)
//   Write channel: S_W_VALID, S_W_ADDR, S_W_DATA (master -> slave)
//                  S_W_READY, S_W_COMPLETE (slave -> master)
//   Error        : oor_err (slave -> master), pulses with the response of an
//                  out-of-range request.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] S_R_ADDR;
    logic                  S_R_ADDR_VALID;
    logic [DATA_WIDTH-1:0] S_R_DATA;
    logic                  S_R_DATA_VALID;
    logic                  S_W_VALID;
    logic [ADDR_WIDTH-1:0] S_W_ADDR;
    logic [DATA_WIDTH-1:0] S_W_DATA;
    logic                  S_W_READY;
    logic                  S_W_COMPLETE;
    logic                  oor_err;

    modport master (
        output S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA,
        input  S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, oor_err
    );

    modport slave (
        input  S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA,
        output S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, oor_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the pipeline data port. Services one read or
//   one write at a time from an internal word-addressed array and answers
//   with a one-cycle data-valid or write-complete pulse after a fixed
//   latency. Writes are committed to the array on the acceptance edge.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high; does not clear the array
//     bus    - data_mem_responder_if slave modport (read/write request
//              channels, read data, write ready/complete, oor_err)
module data_mem_responder #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH         = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
    logic                  rdValid_q, rdValid_d;
    logic                  wrComplete_q, wrComplete_d;
    logic                  oorErr_q, oorErr_d;
    logic                  memWe;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      rdIdx;
    logic [IDX_W-1:0]      wrIdx;
    logic                  rdOor;
    logic                  wrOor;

    // Byte address -> word index; bits [2:0] select a byte within the word
    // and are ignored. Any set bit above the index field means the address
    // is at or beyond DEPTH*8.
    assign rdIdx = bus.S_R_ADDR[IDX_W+2:3];
    assign wrIdx = bus.S_W_ADDR[IDX_W+2:3];
    assign rdOor = (bus.S_R_ADDR >> (IDX_W + 3)) != '0;
    assign wrOor = (bus.S_W_ADDR >> (IDX_W + 3)) != '0;

    // State and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            oor_q        <= 1'b0;
            rdData_q     <= '0;
            rdValid_q    <= 1'b0;
            wrComplete_q <= 1'b0;
            oorErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            oor_q        <= oor_d;
            rdData_q     <= rdData_d;
            rdValid_q    <= rdValid_d;
            wrComplete_q <= wrComplete_d;
            oorErr_q     <= oorErr_d;
        end
    end

    // Storage. Not reset; a write is committed on the edge it is accepted,
    // so a reset arriving later leaves it in place.
    always_ff @(posedge clk) begin
        if (memWe && !reset) begin
            mem[wrIdx] <= bus.S_W_DATA;
        end
    end

    // Next-state and response logic. Pulses default low so each response
    // lasts exactly one cycle; read data holds between reads.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        oor_d        = oor_q;
        rdData_d     = rdData_q;
        rdValid_d    = 1'b0;
        wrComplete_d = 1'b0;
        oorErr_d     = 1'b0;
        memWe        = 1'b0;

        case (state_q)
            IDLE: begin
                // Reads take priority over a simultaneous write.
                if (bus.S_R_ADDR_VALID) begin
                    idx_d   = rdIdx;
                    oor_d   = rdOor;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = RD_WAIT;
                end else if (bus.S_W_VALID) begin
                    oor_d   = wrOor;
                    memWe   = !wrOor;
                    cnt_d   = CNT_W'(WRITE_LATENCY - 1);
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rdData_d  = oor_q ? '0 : mem[idx_q];
                    rdValid_d = 1'b1;
                    oorErr_d  = oor_q;
                    state_d   = RD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_DONE: begin
                // The requester drops valid one cycle after seeing data;
                // waiting here keeps that lag from starting a second read.
                if (!bus.S_R_ADDR_VALID) begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    wrComplete_d = 1'b1;
                    oorErr_d     = oor_q;
                    state_d      = WR_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_DONE: begin
                if (!bus.S_W_VALID) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.S_R_DATA       = rdData_q;
    assign bus.S_R_DATA_VALID = rdValid_q;
    assign bus.S_W_COMPLETE   = wrComplete_q;
    assign bus.oor_err        = oorErr_q;
    assign bus.S_W_READY      = (state_q == IDLE) && !bus.S_R_ADDR_VALID;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. A transaction-level model
//   (acceptance cycle stamp + fixed latency, associative-array memory)
//   predicts every response; a compare process checks the DUT against it on
//   each falling edge. Directed scenarios add hand-computed literal checks,
//   then randomized request episodes exercise the rest.
module tb_data_mem_responder;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;
    localparam int WL    = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    data_mem_responder #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rv, input logic [63:0] ra, input bit wv,
                                 input logic [63:0] wa, input logic [63:0] wd);
        bus.S_R_ADDR_VALID = rv;
        bus.S_R_ADDR       = ra;
        bus.S_W_VALID      = wv;
        bus.S_W_ADDR       = wa;
        bus.S_W_DATA       = wd;
    endtask

    // Reference model: one outstanding transaction described by its kind,
    // target word, and the cycle its response is due.
    bit [63:0]   mdlMem [int unsigned];
    bit          busy;
    bit          isRd;
    bit          fired;
    bit          pendOor;
    int unsigned pendIdx;
    longint      cyc = 0;
    longint      fireAt;
    logic [63:0] expData = '0;
    bit          expDataKnown;
    bit          expRv;
    bit          expWc;
    bit          expOor;
    bit          started = 1'b0;

    function automatic bit isOor(input logic [63:0] a);
        return a >= 64'(DEPTH * 8);
    endfunction

    function automatic int unsigned wordOf(input logic [63:0] a);
        return int'(a / 64'd8);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            busy         = 1'b0;
            expRv        = 1'b0;
            expWc        = 1'b0;
            expOor       = 1'b0;
            expData      = '0;
            expDataKnown = 1'b1;
        end else begin
            expRv  = 1'b0;
            expWc  = 1'b0;
            expOor = 1'b0;
            if (!busy) begin
                if (bus.S_R_ADDR_VALID) begin
                    busy    = 1'b1;
                    isRd    = 1'b1;
                    fired   = 1'b0;
                    pendOor = isOor(bus.S_R_ADDR);
                    pendIdx = pendOor ? 0 : wordOf(bus.S_R_ADDR);
                    fireAt  = cyc + RL;
                end else if (bus.S_W_VALID) begin
                    busy    = 1'b1;
                    isRd    = 1'b0;
                    fired   = 1'b0;
                    pendOor = isOor(bus.S_W_ADDR);
                    if (!pendOor) mdlMem[wordOf(bus.S_W_ADDR)] = bus.S_W_DATA;
                    fireAt  = cyc + WL;
                end
            end else if (!fired) begin
                if (cyc == fireAt) begin
                    fired  = 1'b1;
                    expOor = pendOor;
                    if (isRd) begin
                        expRv = 1'b1;
                        if (pendOor) begin
                            expData      = '0;
                            expDataKnown = 1'b1;
                        end else if (mdlMem.exists(pendIdx)) begin
                            expData      = mdlMem[pendIdx];
                            expDataKnown = 1'b1;
                        end else begin
                            expDataKnown = 1'b0;
                        end
                    end else begin
                        expWc = 1'b1;
                    end
                end
            end else begin
                if (isRd ? !bus.S_R_ADDR_VALID : !bus.S_W_VALID) busy = 1'b0;
            end
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("rdValid", 64'(bus.S_R_DATA_VALID), 64'(expRv));
            checkOutput("wrComplete", 64'(bus.S_W_COMPLETE), 64'(expWc));
            checkOutput("oorErr", 64'(bus.oor_err), 64'(expOor));
            checkOutput("wrReady", 64'(bus.S_W_READY), 64'(!busy && !bus.S_R_ADDR_VALID));
            if (expDataKnown) checkOutput("rdData", bus.S_R_DATA, expData);
        end
    end

    // One request from an idle responder: returns the number of edges from
    // acceptance to the response pulse, plus the sampled data and error.
    task automatic runReq(input bit rd, input logic [63:0] addr, input logic [63:0] data,
                          input int hold, output int lat, output logic [63:0] rdata,
                          output logic oorSeen);
        lat     = 0;
        rdata   = '0;
        oorSeen = 1'b0;
        @(posedge clk);
        #1;
        if (rd) applyStimulus(1'b1, addr, 1'b0, '0, '0);
        else    applyStimulus(1'b0, '0, 1'b1, addr, data);
        @(posedge clk);
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd ? bus.S_R_DATA_VALID : bus.S_W_COMPLETE) begin
                lat     = i;
                rdata   = bus.S_R_DATA;
                oorSeen = bus.oor_err;
            end
        end
        if (lat == 0) checkOutput("pulseTimeout", 64'd0, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("noSecondPulse", 64'(rd ? bus.S_R_DATA_VALID : bus.S_W_COMPLETE), 64'd0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        @(posedge clk);
    endtask

    function automatic logic [63:0] randAddr();
        logic [63:0] a;
        int unsigned sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: a = 64'h0;
            1: a = 64'h8;
            2: a = 64'h28;
            3: a = 64'h40;
            4: a = 64'h48;
            5: a = 64'h1FF8;
            6: a = 64'h100;
            7: a = 64'h2000;
            8: a = 64'h2008;
            default: a = 64'hFFFF_FFFF_FFFF_FFF8;
        endcase
        return a | 64'($urandom_range(0, 7));
    endfunction

    int          lat;
    logic [63:0] rdata;
    logic        oorSeen;

    initial begin
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        reset = 1'b1;
        @(posedge clk);
        #1 started = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("resetData", bus.S_R_DATA, 64'd0);
        checkOutput("resetReady", 64'(bus.S_W_READY), 64'd1);
        checkOutput("resetValid", 64'(bus.S_R_DATA_VALID), 64'd0);

        runReq(1'b0, 64'h0, 64'h1234, 0, lat, rdata, oorSeen);

        runReq(1'b0, 64'h40, 64'hDEAD_BEEF_0000_0001, 0, lat, rdata, oorSeen);
        checkOutput("wrLatency", 64'(lat), 64'd2);
        runReq(1'b1, 64'h40, '0, 0, lat, rdata, oorSeen);
        checkOutput("rdLatency", 64'(lat), 64'd2);
        checkOutput("rdDeadBeef", rdata, 64'hDEAD_BEEF_0000_0001);
        checkOutput("rdInRangeOor", 64'(oorSeen), 64'd0);

        runReq(1'b0, 64'h40, 64'h55, 0, lat, rdata, oorSeen);
        runReq(1'b1, 64'h47, '0, 0, lat, rdata, oorSeen);
        checkOutput("rdLowBitsIgnored", rdata, 64'h55);

        // Simultaneous read and write: read first, write after read valid drops.
        @(posedge clk);
        #1 applyStimulus(1'b1, 64'h40, 1'b1, 64'h48, 64'h77);
        @(negedge clk);
        checkOutput("simReadyLow", 64'(bus.S_W_READY), 64'd0);
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("simNoEarlyWrite", 64'(bus.S_W_COMPLETE), 64'd0);
            if (bus.S_R_DATA_VALID) lat = i;
        end
        checkOutput("simRdLatency", 64'(lat), 64'd2);
        checkOutput("simRdData", bus.S_R_DATA, 64'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("holdNoRepeat", 64'(bus.S_R_DATA_VALID), 64'd0);
            checkOutput("holdReadyLow", 64'(bus.S_W_READY), 64'd0);
        end
        applyStimulus(1'b0, '0, 1'b1, 64'h48, 64'h77);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.S_W_COMPLETE) lat = i;
        end
        checkOutput("simWrDeferred", 64'(lat), 64'd4);
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        @(posedge clk);
        runReq(1'b1, 64'h48, '0, 0, lat, rdata, oorSeen);
        checkOutput("simWrData", rdata, 64'h77);

        // Out-of-range read and write.
        runReq(1'b1, 64'h2000, '0, 0, lat, rdata, oorSeen);
        checkOutput("oorRdData", rdata, 64'd0);
        checkOutput("oorRdErr", 64'(oorSeen), 64'd1);
        runReq(1'b0, 64'h2000, 64'hBAD, 0, lat, rdata, oorSeen);
        checkOutput("oorWrErr", 64'(oorSeen), 64'd1);
        runReq(1'b1, 64'h0, '0, 0, lat, rdata, oorSeen);
        checkOutput("word0Intact", rdata, 64'h1234);

        // Reset one cycle after read acceptance.
        @(posedge clk);
        #1 applyStimulus(1'b1, 64'h40, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abortNoValid", 64'(bus.S_R_DATA_VALID), 64'd0);
            checkOutput("abortData", bus.S_R_DATA, 64'd0);
        end
        runReq(1'b1, 64'h48, '0, 0, lat, rdata, oorSeen);
        checkOutput("afterResetRead", rdata, 64'h77);

        // Randomized episodes; the model judges every cycle.
        for (int ep = 0; ep < 400; ep++) begin
            bit          rv;
            bit          wv;
            logic [63:0] ra;
            logic [63:0] wa;
            int          dur;
            rv  = ($urandom_range(0, 2) == 0);
            wv  = ($urandom_range(0, 1) == 0);
            ra  = randAddr();
            wa  = randAddr();
            dur = $urandom_range(1, 6);
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < dur; c++) begin
                applyStimulus(rv, ra, wv, wa, {$urandom, $urandom});
                @(posedge clk);
                #1 reset = 1'b0;
            end
            applyStimulus(1'b0, '0, 1'b0, '0, '0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
